fifo_switch_scheduler: RTL and testbench

Scheduler for the 4-in/4-out FIFO switch: moves words from input FIFOs 0–3 to output FIFOs 4–7. Each input word carries its destination in bits [9:8] (0→FIFO4 … 3→FIFO7) and payload in [7:0]. The block arbitrates round-robin among non-empty inputs, issues the pop to the source FIFO and the push to the destination FIFO, and respects destination back-pressure. It sits between the input-FIFO bank and the output-FIFO bank, replacing direct stimulus on those pops and pushes.

---
 rtl/switch_pkg.sv | 21 ++
 rtl/rr_pick4.sv | 34 +++
 rtl/fifo_switch_scheduler.sv | 155 +++++++++++++++
 tb/tb_fifo_switch_scheduler.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_pkg
//  Description : Shared constants and state encoding for the 4-in/4-out
//                FIFO switch scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package switch_pkg;

  localparam int WIDTH    = 10;
  localparam int DEST_MSB = 9;
  localparam int DEST_LSB = 8;
  localparam int NPORTS   = 4;

  typedef enum logic [0:0] {
    ST_INIT   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick4
//  Description : Combinational 4-way round-robin picker. The search starts
//                one past last_grant; the first eligible requester wins.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick4
  import switch_pkg::*;
(
  input  logic [NPORTS-1:0] eligible,
  input  logic [1:0]        last_grant,
  output logic              grant_valid,
  output logic [1:0]        grant_idx
);

  logic [1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest eligible one is written last and wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_grant;
    cand        = last_grant;
    for (int k = NPORTS; k >= 1; k--) begin
      cand = last_grant + 2'(k);
      if (eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_switch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_switch_scheduler
//  Description : Moves words from input FIFOs 0-3 to output FIFOs 4-7 using
//                round-robin arbitration with destination back-pressure.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_switch_scheduler #(
  parameter int WIDTH       = 10,
  parameter int INIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] fifo0_out,
  input  logic [WIDTH-1:0] fifo1_out,
  input  logic [WIDTH-1:0] fifo2_out,
  input  logic [WIDTH-1:0] fifo3_out,
  input  logic             empty0,
  input  logic             empty1,
  input  logic             empty2,
  input  logic             empty3,
  input  logic             almost_full4,
  input  logic             almost_full5,
  input  logic             almost_full6,
  input  logic             almost_full7,
  output logic             pop0,
  output logic             pop1,
  output logic             pop2,
  output logic             pop3,
  output logic [WIDTH-1:0] fifo4_i,
  output logic [WIDTH-1:0] fifo5_i,
  output logic [WIDTH-1:0] fifo6_i,
  output logic [WIDTH-1:0] fifo7_i,
  output logic             push4,
  output logic             push5,
  output logic             push6,
  output logic             push7,
  output logic             idle
);
  import switch_pkg::*;

  localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  logic [WIDTH-1:0]  in_word [NPORTS];
  logic [NPORTS-1:0] empty_v;
  logic [NPORTS-1:0] af_v;
  logic [NPORTS-1:0] eligible;
  logic              grant_valid;
  logic [1:0]        grant_idx;
  logic [WIDTH-1:0]  grant_word;
  logic [1:0]        grant_dest;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        last_grant_q, last_grant_d;
  logic [NPORTS-1:0] pop_q, pop_d;
  logic [NPORTS-1:0] push_q, push_d;
  logic [WIDTH-1:0]  data_q [NPORTS];
  logic [WIDTH-1:0]  data_d [NPORTS];
  logic              idle_q, idle_d;

  assign in_word[0] = fifo0_out;
  assign in_word[1] = fifo1_out;
  assign in_word[2] = fifo2_out;
  assign in_word[3] = fifo3_out;
  assign empty_v    = {empty3, empty2, empty1, empty0};
  assign af_v       = {almost_full7, almost_full6, almost_full5, almost_full4};

  // An input whose pop is currently on the wire (pop_q) still shows the old head, so it sits out this cycle
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NPORTS; i++) begin
      eligible[i] = (state_q == ST_ACTIVE) && !empty_v[i] &&
                    !af_v[in_word[i][DEST_MSB:DEST_LSB]] && !pop_q[i];
    end
  end

  rr_pick4 u_pick (
    .eligible    (eligible),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign grant_word = in_word[grant_idx];
  assign grant_dest = grant_word[DEST_MSB:DEST_LSB];

  // Next-state: INIT countdown, pointer update and registered strobe/data selection
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    pop_d        = '0;
    push_d       = '0;
    data_d       = data_q;
    idle_d       = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (grant_valid) begin
          pop_d[grant_idx]   = 1'b1;
          push_d[grant_dest] = 1'b1;
          data_d[grant_dest] = grant_word;
          last_grant_d       = grant_idx;
        end
        // Idle flags a decision cycle that produced no transfer
        idle_d = !grant_valid;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State, pointer and output registers; reset drops all strobes immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      last_grant_q <= 2'd3;
      pop_q        <= '0;
      push_q       <= '0;
      idle_q       <= 1'b0;
      for (int i = 0; i < NPORTS; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      pop_q        <= pop_d;
      push_q       <= push_d;
      idle_q       <= idle_d;
      for (int i = 0; i < NPORTS; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign {pop3, pop2, pop1, pop0}     = pop_q;
  assign {push7, push6, push5, push4} = push_q;
  assign fifo4_i = data_q[0];
  assign fifo5_i = data_q[1];
  assign fifo6_i = data_q[2];
  assign fifo7_i = data_q[3];
  assign idle    = idle_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_switch_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_switch_scheduler
//  Description : Bench for fifo_switch_scheduler with queue-based FIFO
//                environment and a reference arbitration model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_switch_scheduler;

  localparam int WIDTH       = 10;
  localparam int INIT_CYCLES = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] fifo0_out, fifo1_out, fifo2_out, fifo3_out;
  logic             empty0, empty1, empty2, empty3;
  logic             almost_full4, almost_full5, almost_full6, almost_full7;
  wire              pop0, pop1, pop2, pop3;
  wire  [WIDTH-1:0] fifo4_i, fifo5_i, fifo6_i, fifo7_i;
  wire              push4, push5, push6, push7;
  wire              idle;

  always #5 clk = ~clk;

  fifo_switch_scheduler #(.WIDTH(WIDTH), .INIT_CYCLES(INIT_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .fifo0_out(fifo0_out), .fifo1_out(fifo1_out), .fifo2_out(fifo2_out), .fifo3_out(fifo3_out),
    .empty0(empty0), .empty1(empty1), .empty2(empty2), .empty3(empty3),
    .almost_full4(almost_full4), .almost_full5(almost_full5),
    .almost_full6(almost_full6), .almost_full7(almost_full7),
    .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
    .fifo4_i(fifo4_i), .fifo5_i(fifo5_i), .fifo6_i(fifo6_i), .fifo7_i(fifo7_i),
    .push4(push4), .push5(push5), .push6(push6), .push7(push7),
    .idle(idle)
  );

  // Environment: input and output FIFO contents
  logic [WIDTH-1:0] in_q  [4][$];
  logic [WIDTH-1:0] out_q [4][$];
  logic [3:0]       af;
  logic [3:0]       pend_pop, pend_push;
  logic [WIDTH-1:0] pend_data [4];

  // Reference model state
  int               m_ptr;
  int               m_last;
  int               init_left;
  bit               in_reset;
  logic [3:0]       e_pop, e_push;
  logic [WIDTH-1:0] e_data [4];
  logic             e_idle;

  int checks = 0;
  int errors = 0;

  function automatic logic [3:0] dut_pop();
    return {pop3, pop2, pop1, pop0};
  endfunction

  function automatic logic [3:0] dut_push();
    return {push7, push6, push5, push4};
  endfunction

  function automatic logic [WIDTH-1:0] dut_data(input int d);
    case (d)
      0:       return fifo4_i;
      1:       return fifo5_i;
      2:       return fifo6_i;
      default: return fifo7_i;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] head(input int i);
    if (in_q[i].size() == 0) return '0;
    return in_q[i][0];
  endfunction

  task automatic drive();
    empty0 = (in_q[0].size() == 0); fifo0_out = head(0);
    empty1 = (in_q[1].size() == 0); fifo1_out = head(1);
    empty2 = (in_q[2].size() == 0); fifo2_out = head(2);
    empty3 = (in_q[3].size() == 0); fifo3_out = head(3);
    {almost_full7, almost_full6, almost_full5, almost_full4} = af;
  endtask

  // Decide what the scheduler should emit after the coming edge
  task automatic model_decide();
    int g, d, i;
    logic [WIDTH-1:0] w;
    e_pop  = '0;
    e_push = '0;
    e_idle = 1'b0;
    if (in_reset) begin
      for (int k = 0; k < 4; k++) e_data[k] = '0;
      return;
    end
    g = -1;
    if (init_left == 0) begin
      for (int k = 1; k <= 4; k++) begin
        i = (m_ptr + k) % 4;
        if (g < 0 && in_q[i].size() > 0 && i != m_last) begin
          w = in_q[i][0];
          if (!af[w[9:8]]) g = i;
        end
      end
    end
    if (g >= 0) begin
      w = in_q[g][0];
      d = int'(w[9:8]);
      e_pop[g]  = 1'b1;
      e_push[d] = 1'b1;
      e_data[d] = w;
      m_ptr     = g;
    end
    m_last = g;
    e_idle = (init_left == 0) && (g < 0);
    if (init_left > 0) init_left--;
  endtask

  task automatic step();
    logic [3:0] sp, su;
    int bad;
    model_decide();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (pend_pop[i]) void'(in_q[i].pop_front());
    for (int d = 0; d < 4; d++) if (pend_push[d]) out_q[d].push_back(pend_data[d]);
    sp = dut_pop();
    su = dut_push();
    checks++;
    if ({su, sp} !== {e_push, e_pop}) begin
      errors++;
      $display("FAIL strobes: got push=%b pop=%b, expected push=%b pop=%b", su, sp, e_push, e_pop);
    end
    bad = -1;
    for (int d = 0; d < 4; d++) if (bad < 0 && dut_data(d) !== e_data[d]) bad = d;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL data fifo%0d_i: got %h, expected %h", bad + 4, dut_data(bad), e_data[bad]);
    end
    checks++;
    if (idle !== e_idle) begin
      errors++;
      $display("FAIL idle: got %b, expected %b", idle, e_idle);
    end
    pend_pop  = sp;
    pend_push = su;
    for (int d = 0; d < 4; d++) pend_data[d] = dut_data(d);
    drive();
  endtask

  // Pull reset mid-cycle, confirm outputs clear at once, hold, then release mid-cycle
  task automatic apply_reset(input int cycles);
    #2;
    reset    = 1'b0;
    in_reset = 1'b1;
    #1;
    checks++;
    if ({dut_pop(), dut_push(), idle} !== 9'b0 ||
        {fifo4_i, fifo5_i, fifo6_i, fifo7_i} !== '0) begin
      errors++;
      $display("FAIL async_reset: got pop=%b push=%b idle=%b, expected all zero", dut_pop(), dut_push(), idle);
    end
    pend_pop  = '0;
    pend_push = '0;
    m_ptr     = 3;
    m_last    = -1;
    for (int d = 0; d < 4; d++) e_data[d] = '0;
    repeat (cycles) step();
    reset     = 1'b1;
    in_reset  = 1'b0;
    init_left = INIT_CYCLES;
  endtask

  task automatic drain();
    int n;
    af = '0;
    drive();
    n = 0;
    while ((in_q[0].size() + in_q[1].size() + in_q[2].size() + in_q[3].size() != 0 ||
            pend_pop != 0 || pend_push != 0) && n < 80) begin
      step();
      n++;
    end
    checks++;
    if (n >= 80) begin
      errors++;
      $display("FAIL drain_timeout: got %0d cycles, expected fewer than 80", n);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      in_q[i].delete();
      in_q[i].push_back(10'($urandom));
    end
    af = '0;
    drive();
    apply_reset(3);
    for (int s = 0; s < INIT_CYCLES; s++) begin
      step();
      checks++;
      if (dut_pop() !== 4'b0 || dut_push() !== 4'b0) begin
        errors++;
        $display("FAIL init_quiet: got pop=%b push=%b in init cycle %0d, expected 0", dut_pop(), dut_push(), s);
      end
    end
    step();
    checks++;
    if (dut_pop() !== 4'b0001) begin
      errors++;
      $display("FAIL first_grant: got pop=%b, expected 0001", dut_pop());
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp_out [4][$];
    int first_s, last_s, pushes, s;
    apply_reset(2);
    for (int d = 0; d < 4; d++) begin
      out_q[d].delete();
      exp_out[d].delete();
    end
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++)
        in_q[i].push_back(10'(((k % 4) << 8) | (i * 16 + k)));
    // Grants rotate 0,1,2,3 so transfer t moves word t/4 of input t%4
    for (int t = 0; t < 32; t++)
      exp_out[(t / 4) % 4].push_back(10'((((t / 4) % 4) << 8) | ((t % 4) * 16 + t / 4)));
    drive();
    first_s = -1; last_s = -1; pushes = 0; s = 0;
    while (pushes < 32 && s < 60) begin
      step();
      if (dut_push() != 0) begin
        pushes++;
        if (first_s < 0) first_s = s;
        last_s = s;
      end
      s++;
    end
    drain();
    checks++;
    if (pushes != 32 || last_s - first_s + 1 != 32) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d pushes over %0d cycles, expected 32 over 32", pushes, last_s - first_s + 1);
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (out_q[d] != exp_out[d]) begin
        errors++;
        $display("FAIL b2b_contents fifo%0d: got %0d words (first %h), expected %0d words (first %h)",
                 d + 4, out_q[d].size(), (out_q[d].size() > 0) ? out_q[d][0] : 10'h0,
                 exp_out[d].size(), exp_out[d][0]);
      end
    end
  endtask

  task automatic test_single_input();
    logic [5:0] pop_seq, idle_seq;
    repeat (2) step();
    for (int k = 0; k < 3; k++) in_q[2].push_back(10'($urandom));
    drive();
    for (int s = 0; s < 6; s++) begin
      step();
      pop_seq[s]  = pop2;
      idle_seq[s] = idle;
    end
    checks++;
    if (pop_seq !== 6'b010101) begin
      errors++;
      $display("FAIL single_pop_pattern: got %b, expected 010101", pop_seq);
    end
    checks++;
    if (idle_seq !== 6'b101010) begin
      errors++;
      $display("FAIL single_idle_gaps: got %b, expected 101010", idle_seq);
    end
    drain();
  endtask

  task automatic test_almost_full();
    int base5, seen;
    repeat (2) step();
    base5 = out_q[1].size();
    in_q[0].push_back(10'h1A5);
    in_q[1].push_back(10'h25A);
    af = 4'b0010;
    drive();
    repeat (4) step();
    checks++;
    if (in_q[0].size() != 1 || in_q[1].size() != 0 || out_q[1].size() != base5) begin
      errors++;
      $display("FAIL af_block: got in0=%0d in1=%0d words, expected in0=1 in1=0", in_q[0].size(), in_q[1].size());
    end
    af = '0;
    drive();
    seen = 0;
    for (int s = 0; s < 2; s++) begin
      step();
      if (push5 === 1'b1 && fifo5_i === 10'h1A5) seen = 1;
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL af_release: got no push5 of 1a5 within 2 cycles, expected one");
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    int base6, n;
    repeat (2) step();
    base6 = out_q[2].size();
    in_q[1].push_back(10'h2C3);
    drive();
    n = 0;
    while (push6 !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n >= 10) begin
      errors++;
      $display("FAIL midflight_push: got no push6 in 10 cycles, expected one");
    end
    apply_reset(2);
    repeat (INIT_CYCLES + 6) step();
    checks++;
    if (out_q[2].size() != base6 + 1 || in_q[1].size() != 0 ||
        out_q[2][out_q[2].size() - 1] !== 10'h2C3) begin
      errors++;
      $display("FAIL midflight_once: got %0d new words in fifo6, expected exactly 1 (2c3)", out_q[2].size() - base6);
    end
  endtask

  task automatic test_idle_empty();
    logic [WIDTH-1:0] held [4];
    int bad;
    repeat (2) step();
    for (int d = 0; d < 4; d++) held[d] = dut_data(d);
    bad = 0;
    for (int s = 0; s < 10; s++) begin
      step();
      if (idle !== 1'b1 || dut_push() !== 4'b0 || dut_pop() !== 4'b0) bad++;
      for (int d = 0; d < 4; d++) if (dut_data(d) !== held[d]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_empty: got %0d deviations over 10 cycles, expected 0", bad);
    end
  endtask

  task automatic test_random();
    int total_in, delivered, bad;
    int base [4];
    total_in = 0;
    for (int d = 0; d < 4; d++) base[d] = out_q[d].size();
    for (int s = 0; s < 300; s++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 2) == 0 && in_q[i].size() < 6) begin
          in_q[i].push_back(10'($urandom));
          total_in++;
        end
      end
      if ($urandom_range(0, 3) == 0) af = 4'($urandom_range(0, 15));
      drive();
      step();
    end
    drain();
    delivered = 0;
    bad = 0;
    for (int d = 0; d < 4; d++) begin
      delivered += out_q[d].size() - base[d];
      for (int j = base[d]; j < out_q[d].size(); j++) begin
        logic [WIDTH-1:0] w;
        w = out_q[d][j];
        if (int'(w[9:8]) != d) bad++;
      end
    end
    checks++;
    if (delivered != total_in) begin
      errors++;
      $display("FAIL random_conservation: got %0d delivered, expected %0d", delivered, total_in);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_routing: got %0d misrouted words, expected 0", bad);
    end
  endtask

  initial begin
    af        = '0;
    pend_pop  = '0;
    pend_push = '0;
    m_ptr     = 3;
    m_last    = -1;
    init_left = INIT_CYCLES;
    in_reset  = 1'b1;
    for (int d = 0; d < 4; d++) begin
      e_data[d]    = '0;
      pend_data[d] = '0;
    end
    drive();
    test_reset();
    test_back_to_back();
    test_single_input();
    test_almost_full();
    test_reset_midflight();
    test_idle_empty();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
